// File: rtl/line_buffer_pkg.sv
// line_buffer_pkg: shared types for the ping-pong scanline buffer.
package line_buffer_pkg;
    typedef enum logic {LB_INIT, LB_RUN} lb_state_t;
    typedef logic bank_sel_t;
endpackage

// File: rtl/line_buffer_bank.sv
// line_buffer_bank: simple dual-port RAM, one write port and a registered read-first read port.
module line_buffer_bank #(
    parameter int PIXEL_W = 8,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [PIXEL_W-1:0] i_wdata,
    input  logic               i_re,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [PIXEL_W-1:0] o_rdata
);
    logic [PIXEL_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/line_buffer_pp.sv
// line_buffer_pp: ping-pong scanline buffer with post-reset clear, clear-on-read
// and sticky overflow/underrun flags.
module line_buffer_pp
    import line_buffer_pkg::*;
#(
    parameter int                 PIXEL_W       = 8,
    parameter int                 DEPTH         = 1024,
    parameter int                 ADDR_W        = $clog2(DEPTH),
    parameter logic [PIXEL_W-1:0] CLEAR_VALUE   = '0,
    parameter bit                 CLEAR_ON_READ = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic               wr_done,
    output logic               wr_ready,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIXEL_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               rd_done,
    output logic               rd_ready,
    output logic               init_busy,
    output logic               ovf_err,
    output logic               udf_err
);
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

    lb_state_t          r_state;
    bank_sel_t          r_wr_bank, r_rd_bank, r_rd_sel;
    logic [1:0]         r_full;
    logic [ADDR_W-1:0]  r_clr_addr;
    logic               r_rd_valid, r_ovf, r_udf;
    logic               w_init, w_wr_acc, w_rd_acc;
    logic [PIXEL_W-1:0] w_rdq [2];

    assign w_init    = r_state == LB_INIT;
    assign wr_ready  = !w_init && !r_full[r_wr_bank];
    assign rd_ready  = !w_init && r_full[r_rd_bank];
    assign w_wr_acc  = wr_en && wr_ready && ({1'b0, wr_addr} < LP_DEPTH);
    assign w_rd_acc  = rd_en && rd_ready && ({1'b0, rd_addr} < LP_DEPTH);
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_valid ? w_rdq[r_rd_sel] : CLEAR_VALUE;
    assign init_busy = w_init;
    assign ovf_err   = r_ovf;
    assign udf_err   = r_udf;

    // Writer and reader never own the same bank in RUN, so at most one of them hits a bank.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_wsel, w_rsel, w_csel;
        assign w_wsel = w_wr_acc && r_wr_bank == bank_sel_t'(b);
        assign w_rsel = w_rd_acc && r_rd_bank == bank_sel_t'(b);
        assign w_csel = CLEAR_ON_READ && w_rsel;
        line_buffer_bank #(.PIXEL_W(PIXEL_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
            .clk     (clk),
            .i_we    (w_init || w_wsel || w_csel),
            .i_waddr (w_init ? r_clr_addr : w_wsel ? wr_addr : rd_addr),
            .i_wdata (w_wsel ? wr_data : CLEAR_VALUE),
            .i_re    (w_rsel),
            .i_raddr (rd_addr),
            .o_rdata (w_rdq[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= LB_INIT;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_rd_sel   <= 1'b0;
            r_full     <= '0;
            r_clr_addr <= '0;
            r_rd_valid <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            r_rd_sel   <= r_rd_bank;
            r_ovf      <= r_ovf || (wr_en && !w_wr_acc);
            r_udf      <= r_udf || (rd_en && !w_rd_acc);
            if (w_init) begin
                r_clr_addr <= r_clr_addr + 1'b1;
                if (r_clr_addr == ADDR_W'(DEPTH-1)) r_state <= LB_RUN;
            end else begin
                if (wr_done && wr_ready) begin
                    r_full[r_wr_bank] <= 1'b1;
                    r_wr_bank         <= ~r_wr_bank;
                end
                if (rd_done && rd_ready) begin
                    r_full[r_rd_bank] <= 1'b0;
                    r_rd_bank         <= ~r_rd_bank;
                end
            end
        end
    end
endmodule

// File: tb/tb_line_buffer_pp.sv
// tb_line_buffer_pp: directed and randomized checks of line_buffer_pp against a line-level model.
module tb_line_buffer_pp;
    localparam int D = 16;

    logic       clk, rst;
    logic       wr_en, wr_done, rd_en, rd_done;
    logic [3:0] wr_addr, rd_addr;
    logic [7:0] wr_data, rd_data;
    logic       wr_ready, rd_valid, rd_ready, init_busy, ovf_err, udf_err;

    int n_cmp = 0;
    int n_err = 0;

    // Model: two line stores, count of full lines, oldest-full and writer line indices.
    logic [7:0] m_mem [2][D];
    int         nf, wb, rb, left;
    bit         m_ovf, m_udf;

    line_buffer_pp #(
        .PIXEL_W(8), .DEPTH(D), .CLEAR_VALUE(8'h00), .CLEAR_ON_READ(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_done(wr_done), .wr_ready(wr_ready),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid), .rd_done(rd_done),
        .rd_ready(rd_ready), .init_busy(init_busy), .ovf_err(ovf_err), .udf_err(udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < D; a++) m_mem[b][a] = 8'h00;
        nf = 0; wb = 0; rb = 0; left = D; m_ovf = 0; m_udf = 0;
    endtask

    task automatic cyc(input bit we, input int wa, input logic [7:0] wd, input bit wdn,
                       input bit re, input int ra, input bit rdn);
        bit run, wok, rok, wacc, racc;
        logic [7:0] ed;
        wr_en = we; wr_addr = 4'(wa); wr_data = wd; wr_done = wdn;
        rd_en = re; rd_addr = 4'(ra); rd_done = rdn;
        run  = left == 0;
        wok  = run && nf < 2;
        rok  = run && nf > 0;
        wacc = we && wok;
        racc = re && rok;
        ed   = racc ? m_mem[rb][ra] : 8'h00;
        if (racc) m_mem[rb][ra] = 8'h00;
        if (wacc) m_mem[wb][wa] = wd;
        if (we && !wacc) m_ovf = 1;
        if (re && !racc) m_udf = 1;
        if (wdn && wok) begin wb ^= 1; nf++; end
        if (rdn && rok) begin rb ^= 1; nf--; end
        if (!run) left--;
        @(posedge clk); #1;
        wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        chk("rd_valid", 8'(rd_valid), 8'(racc));
        chk("rd_data", rd_data, ed);
        chk("wr_ready", 8'(wr_ready), 8'(left == 0 && nf < 2));
        chk("rd_ready", 8'(rd_ready), 8'(left == 0 && nf > 0));
        chk("init_busy", 8'(init_busy), 8'(left > 0));
        chk("ovf_err", 8'(ovf_err), 8'(m_ovf));
        chk("udf_err", 8'(udf_err), 8'(m_udf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 8'h00, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        chk("rst_rd_valid", 8'(rd_valid), 8'h00);
        chk("rst_init_busy", 8'(init_busy), 8'h01);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_ready", 8'({wr_ready, rd_ready}), 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic rand_phase(input int n);
        for (int i = 0; i < n; i++)
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, D-1), 8'($urandom),
                $urandom_range(0, 19) == 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, D-1), $urandom_range(0, 19) == 0);
    endtask

    logic [7:0] b1 [D];
    logic [7:0] v;

    initial begin
        rst = 1'b1; wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        @(posedge clk); #1;
        do_reset();
        // 1: init lasts D cycles, first handed-over line reads as cleared
        idle(D - 1);
        chk("s1_busy_last", 8'(init_busy), 8'h01);
        idle(1);
        chk("s1_wr_ready", 8'(wr_ready), 8'h01);
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 8'h00, 0, 1, i, 0);
            chk("s1_clear", rd_data, 8'h00);
        end
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        // 2: fill, read back, then verify clear-on-read on the same bank
        for (int i = 0; i < D; i++) cyc(1, i, 8'(8'h10 + i), 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        chk("s2_rd_ready", 8'(rd_ready), 8'h01);
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 8'h00, 0, 1, i, 0);
            chk("s2_data", rd_data, 8'(8'h10 + i));
            chk("s2_valid", 8'(rd_valid), 8'h01);
        end
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            cyc(0, 0, 8'h00, 0, 1, i, 0);
            chk("s2_reread", rd_data, 8'h00);
        end
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        // 4: simultaneous write, handover, read and release
        for (int i = 0; i < D; i++) begin
            b1[i] = 8'($urandom);
            cyc(1, i, b1[i], 0, 0, 0, 0);
        end
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        cyc(1, 5, 8'hAA, 1, 1, 7, 1);
        chk("s4_old_read", rd_data, b1[7]);
        chk("s4_flags", 8'({ovf_err, udf_err}), 8'h00);
        cyc(0, 0, 8'h00, 0, 1, 5, 0);
        chk("s4_new_data", rd_data, 8'hAA);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        // 3: both banks full, rejected write, release
        for (int i = 0; i < D; i++) cyc(1, i, 8'($urandom), 0, 0, 0, 0);
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        for (int i = 0; i < D; i++) begin
            b1[i] = 8'($urandom);
            cyc(1, i, b1[i], 0, 0, 0, 0);
        end
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        chk("s3_full", 8'(wr_ready), 8'h00);
        v = ~b1[3];
        cyc(1, 3, v, 0, 0, 0, 0);
        chk("s3_ovf", 8'(ovf_err), 8'h01);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        chk("s3_wr_ready", 8'(wr_ready), 8'h01);
        cyc(0, 0, 8'h00, 0, 1, 3, 0);
        chk("s3_unchanged", rd_data, b1[3]);
        cyc(0, 0, 8'h00, 0, 0, 0, 1);
        // 5: read with nothing to read
        cyc(0, 0, 8'h00, 0, 1, 2, 0);
        chk("s5_valid", 8'(rd_valid), 8'h00);
        chk("s5_data", rd_data, 8'h00);
        chk("s5_udf", 8'(udf_err), 8'h01);
        idle(5);
        chk("s5_sticky", 8'(udf_err), 8'h01);
        // 6: reset in the middle of a read burst
        cyc(1, 1, 8'h77, 1, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 1, 1, 0);
        chk("s6_pre_valid", 8'(rd_valid), 8'h01);
        do_reset();
        idle(D);
        chk("s6_rd_ready", 8'(rd_ready), 8'h00);
        chk("s6_wr_ready", 8'(wr_ready), 8'h01);
        cyc(0, 0, 8'h00, 1, 0, 0, 0);
        cyc(0, 0, 8'h00, 0, 1, 1, 0);
        chk("s6_cleared", rd_data, 8'h00);
        // Randomized traffic, then again including strobes during init
        rand_phase(600);
        do_reset();
        rand_phase(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/line_buffer_pp.md
Name: line_buffer_pp

Overview:
Parametrised ping-pong scanline buffer with two banks of DEPTH pixels each. The renderer fills one bank while the display scan-out drains the other. Bank ownership is exchanged through done/ready handshakes. Adds three things a plain dual-port RAM lacks: a post-reset hardware clear, an optional clear-on-read, and sticky overflow/underrun flags.

Parameters:
PIXEL_W, 8, pixel width in bits
DEPTH, 1024, pixels per bank (any value ≥ 2, not necessarily a power of 2)
ADDR_W, $clog2(DEPTH), address width
CLEAR_VALUE, '0, value written by the init clear and by clear-on-read
CLEAR_ON_READ, 1, 1 = every accepted read writes CLEAR_VALUE back to the same address

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
wr_en  in  1  renderer pixel write strobe
wr_addr  in  ADDR_W  pixel index within the write bank
wr_data  in  PIXEL_W  pixel value
wr_done  in  1  pulse: renderer finished the line and hands the bank over
wr_ready  out  1  write bank is owned by the renderer
rd_en  in  1  scan-out read strobe
rd_addr  in  ADDR_W  pixel index within the read bank
rd_data  out  PIXEL_W  read data, 1 cycle after rd_en
rd_valid  out  1  rd_data carries an accepted read
rd_done  in  1  pulse: scan-out finished the line and releases the bank
rd_ready  out  1  a full bank is available for reading
init_busy  out  1  post-reset clear in progress
ovf_err  out  1  sticky: write attempted while !wr_ready or with addr ≥ DEPTH
udf_err  out  1  sticky: read attempted while !rd_ready or with addr ≥ DEPTH

Behaviour:
- Reset (async assert, sync release):
  - FSM = INIT; wr_bank = 0; rd_bank = 0; full[1:0] = 0; clr_addr = 0.
  - All outputs 0, except init_busy = 1.
  - Asserting reset mid-line discards both banks and restarts INIT.
  - rd_valid is cleared immediately on reset.
- INIT state:
  - Each cycle writes CLEAR_VALUE to address clr_addr in both banks, then clr_addr++.
  - After address DEPTH-1 the FSM moves to RUN. INIT therefore lasts exactly DEPTH cycles.
  - wr_ready = rd_ready = 0 throughout; any user strobe during INIT sets the matching error flag and is dropped.
- RUN state:
  - wr_ready = !full[wr_bank]; rd_ready = full[rd_bank].
  - Write accepted when wr_en & wr_ready & wr_addr < DEPTH. Written to bank wr_bank in the same edge.
  - Read accepted when rd_en & rd_ready & rd_addr < DEPTH.
    - rd_data = old content of bank rd_bank at rd_addr, registered; latency 1.
    - rd_valid = 1 in the following cycle.
    - With CLEAR_ON_READ = 1, the same edge writes CLEAR_VALUE to that address (read-first).
  - A rejected read gives rd_valid = 0 and rd_data = CLEAR_VALUE on the next cycle.
  - wr_done while wr_ready: full[wr_bank] <= 1 and wr_bank flips. A wr_en in the same cycle still lands in the old bank.
  - rd_done while rd_ready: full[rd_bank] <= 0 and rd_bank flips. An rd_en in the same cycle still reads the old bank.
  - wr_done while !wr_ready, or rd_done while !rd_ready: ignored, no flag set.
  - wr_done and rd_done in the same cycle act on different banks; both take effect.
  - Both banks full: wr_ready = 0 until the next rd_done; wr_ready rises the cycle after it.
  - Both banks empty: rd_ready = 0 until the next wr_done; rd_ready rises the cycle after it.
- Writer and reader never own the same bank in RUN. Per bank, the write-port mux selects, in priority order: INIT clear, renderer, read-clear.
- ovf_err / udf_err are set on the cycle after the offending strobe and cleared only by rst.

Decomposition:
- Package line_buffer_pkg: typedef enum {LB_INIT, LB_RUN} lb_state_t; typedef logic bank_sel_t.
- Sub-module line_buffer_bank: simple dual-port RAM with one write port and one registered read-first read port, parametrised by PIXEL_W and DEPTH. Instantiated twice.
- Top level holds the FSM, ownership logic, port muxing and flags.

Test Plan:
All scenarios use DEPTH=16, PIXEL_W=8, CLEAR_VALUE=8'h00, CLEAR_ON_READ=1 unless stated otherwise.
1. Release rst -> init_busy high exactly 16 cycles. Then wr_ready=1, rd_ready=0, and reading any address after the first handover returns 8'h00.
2. Write data=addr+8'h10 to addresses 0..15, then wr_done -> rd_ready=1 the next cycle. Reads of 0..15 return 8'h10..8'h1F with 1-cycle latency and rd_valid each cycle. After rd_done and a second writer handover with no writes, the bank re-read returns all 8'h00.
3. Fill bank0 and wr_done; fill bank1 and wr_done -> wr_ready=0. Write strobe to addr 3 sets ovf_err, and bank1 addr 3 is unchanged. rd_done -> wr_ready=1 the next cycle.
4. In the same cycle: wr_en addr 5 data 8'hAA, wr_done, rd_en, rd_done -> 8'hAA is in the handed-over bank, the read returns old-bank data, both swaps occur, and no flags are set.
5. rd_en with rd_ready=0 -> rd_valid=0, rd_data=8'h00, udf_err=1. The flag stays set until rst.
6. Assert rst mid-read -> rd_valid drops immediately and init_busy=1. Re-run INIT, then confirm rd_ready=0 and the full flags are cleared.
